bram_dual_port: RTL and testbench
=================================

// Module: bram_dual_port
// PURPOSE
//  Parametrised true-dual-port block RAM: two independent read/write ports (A, B) sharing one clock.
//  Per-byte write enables, selectable write mode, selectable read latency (1 or 2), plus a per-port read-valid strobe.
//  Intended to replace fixed single-port BRAM IP in designs needing a shared buffer or ping-pong buffer.
// PARAMETERS
//  P_DWIDTH   32                  data width in bits per port; multiple of 8
//  P_SIZE     8*1024              memory size in bytes
//  P_EWIDTH   P_DWIDTH/8          byte-enable width (derived)
//  P_DEPTH    P_SIZE/(P_DWIDTH/8) number of words (derived)
//  P_AWIDTH   $clog2(P_DEPTH)     word-address width (derived)
//  P_LATENCY  1                   read latency in cycles; 1 or 2 (2 adds an output register)
//  P_WMODE    0                   0=READ_FIRST, 1=WRITE_FIRST, 2=NO_CHANGE (applies to both ports)
// PORTS
//  CLK      in   1         single clock; all ports sample on the rising edge
//  RESETn   in   1         asynchronous active-low reset
//  ADDRA    in   P_AWIDTH  port A word address
//  ENA      in   1         port A enable; ADDRA, WEA and DINA are ignored when low
//  WEA      in   P_EWIDTH  port A byte write enables; all zero = read
//  DINA     in   P_DWIDTH  port A write data
//  DOUTA    out  P_DWIDTH  port A read data
//  VALIDA   out  1         port A read-data-valid pulse (1 cycle)
//  ADDRB/ENB/WEB/DINB/DOUTB/VALIDB  same as A, for port B
// BEHAVIOUR
//  - Reset: DOUTA/DOUTB=0, VALIDA/VALIDB=0, all pipeline stages cleared. Memory array is NOT reset.
//  - Access cycle: edge t with EN=1. A write applies only the bytes where WE[i]=1; other bytes are unchanged.
//  - Data-producing access:
//      READ_FIRST:  any EN=1 cycle; output is the old word.
//      WRITE_FIRST: any EN=1 cycle; output is the new word, merged per byte.
//      NO_CHANGE:   EN=1 and WE=0 only; on write cycles DOUT holds and VALID stays 0.
//  - Latency 1: DOUT and VALID update on edge t. VALID is high for the cycle between t and t+1.
//  - Latency 2: stage 1 captures on edge t; the output register loads at t+1. VALID is high between t+1 and t+2.
//  - DOUT holds its last value whenever no new data arrives; VALID is 0 in those cycles.
//  - Back-to-back accesses are fully pipelined at 1 per cycle per port, in both latency modes.
//  - Cross-port, same address, same edge:
//      A writes, B reads: B returns the OLD word regardless of P_WMODE.
//      Both write: for bytes enabled on both ports, A wins; bytes enabled on one port only take that port's data.
//  - Address range is 0..P_DEPTH-1. P_DEPTH is a power of two, so there is no out-of-range case.
//  - Reset asserted mid-operation: VALID and DOUT clear immediately and in-flight stage-2 data is discarded.
//    Writes already committed to the array persist.
//    The first access after RESETn rises is sampled on the first full edge.
//  - Elaboration error if P_LATENCY not in {1,2}, P_WMODE>2, or P_DWIDTH%8!=0.
//  - Memory inferred as reg array with per-byte write loop; synthesises to BRAM.
// TESTING
//  1. Full-word fill, P_LATENCY=1, port A:
//     write 0x44332211 (+0x11111111 per word) to words 0..3, WEA=4'hF, then read words 0..3
//     -> DOUTA = 0x44332211, 0x55443322, 0x66554433, 0x77665544, each with a 1-cycle VALIDA.
//  2. Byte-enable write:
//     word 5 = 0x44332211, then write 0xAABBCCDD with WEA=4'b0101, then read on port B
//     -> DOUTB = 0x44BB22DD.
//  3. Write mode, writing 0xDEADBEEF over 0x12345678 via port A:
//     READ_FIRST -> DOUTA=0x12345678, VALIDA=1
//     WRITE_FIRST -> DOUTA=0xDEADBEEF, VALIDA=1
//     NO_CHANGE -> DOUTA holds previous value, VALIDA=0
//  4. Collision at word 7:
//     A writes 0x11111111 (WEA=4'hF) while B writes 0x22222222 (WEB=4'b1100)
//     -> word 7 = 0x11111111.
//     A writes 0xCAFEF00D while B reads word 7
//     -> DOUTB = 0x11111111, and a later read of word 7 returns 0xCAFEF00D.
//  5. P_LATENCY=2, reads of words 0..3 on 4 consecutive edges
//     -> VALIDA high on 4 consecutive cycles starting 2 edges after the first read, data in order.
//  6. Reset mid-read, P_LATENCY=2:
//     pulse RESETn low between the read edge and the output edge
//     -> DOUTA=0 and VALIDA=0 immediately, no VALIDA pulse afterwards, memory contents intact on re-read.

Source files
------------

// File: rtl/bram_dual_port.sv
`default_nettype none
// ============================================================================
//  Module      : bram_dual_port
//  Description : True-dual-port byte-writable block RAM, one clock, read
//                latency 1 or 2, selectable write mode, per-port read-valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module bram_dual_port #(
  parameter int P_DWIDTH  = 32,
  parameter int P_SIZE    = 8*1024,
  parameter int P_EWIDTH  = P_DWIDTH/8,
  parameter int P_DEPTH   = P_SIZE/(P_DWIDTH/8),
  parameter int P_AWIDTH  = $clog2(P_DEPTH),
  parameter int P_LATENCY = 1,
  parameter int P_WMODE   = 0
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [P_AWIDTH-1:0] ADDRA,
  input  logic                ENA,
  input  logic [P_EWIDTH-1:0] WEA,
  input  logic [P_DWIDTH-1:0] DINA,
  output logic [P_DWIDTH-1:0] DOUTA,
  output logic                VALIDA,
  input  logic [P_AWIDTH-1:0] ADDRB,
  input  logic                ENB,
  input  logic [P_EWIDTH-1:0] WEB,
  input  logic [P_DWIDTH-1:0] DINB,
  output logic [P_DWIDTH-1:0] DOUTB,
  output logic                VALIDB
);

  localparam int c_WRITE_FIRST = 1;
  localparam int c_NO_CHANGE   = 2;

  if (P_LATENCY != 1 && P_LATENCY != 2) begin : g_err_latency
    $error("bram_dual_port: P_LATENCY must be 1 or 2");
  end
  if (P_WMODE < 0 || P_WMODE > 2) begin : g_err_wmode
    $error("bram_dual_port: P_WMODE must be 0, 1 or 2");
  end
  if (P_DWIDTH % 8 != 0) begin : g_err_dwidth
    $error("bram_dual_port: P_DWIDTH must be a multiple of 8");
  end

  logic [P_DWIDTH-1:0] r_mem [P_DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [P_AWIDTH-1:0] w_addr [2];
  logic                w_en   [2];
  logic [P_EWIDTH-1:0] w_we   [2];
  logic [P_DWIDTH-1:0] w_din  [2];
  logic [P_DWIDTH-1:0] w_dout [2];
  logic                w_vld  [2];

  assign w_addr[0] = ADDRA;
  assign w_addr[1] = ADDRB;
  assign w_en[0]   = ENA;
  assign w_en[1]   = ENB;
  assign w_we[0]   = WEA;
  assign w_we[1]   = WEB;
  assign w_din[0]  = DINA;
  assign w_din[1]  = DINB;
  assign DOUTA     = w_dout[0];
  assign VALIDA    = w_vld[0];
  assign DOUTB     = w_dout[1];
  assign VALIDB    = w_vld[1];

  // Port B is applied first so that port A wins on bytes both ports enable.
  always_ff @(posedge CLK) begin
    for (int p = 1; p >= 0; p--) begin
      if (w_en[p]) begin
        for (int i = 0; i < P_EWIDTH; i++) begin
          if (w_we[p][i]) begin
            r_mem[w_addr[p]][8*i +: 8] <= w_din[p][8*i +: 8];
          end
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [P_DWIDTH-1:0] w_old;
    logic [P_DWIDTH-1:0] w_new;
    logic [P_DWIDTH-1:0] w_rd;
    logic                w_produce;
    logic [P_DWIDTH-1:0] r_s1_data;
    logic                r_s1_vld;

    // w_old is the pre-edge word, so a cross-port write is never visible here.
    assign w_old = r_mem[w_addr[p]];

    always_comb begin
      w_new = w_old;
      for (int i = 0; i < P_EWIDTH; i++) begin
        if (w_we[p][i]) begin
          w_new[8*i +: 8] = w_din[p][8*i +: 8];
        end
      end
    end

    assign w_rd      = (P_WMODE == c_WRITE_FIRST) ? w_new : w_old;
    assign w_produce = w_en[p] && ((P_WMODE != c_NO_CHANGE) || (w_we[p] == '0));

    always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
        r_s1_data <= '0;
        r_s1_vld  <= 1'b0;
      end else begin
        r_s1_vld <= w_produce;
        if (w_produce) begin
          r_s1_data <= w_rd;
        end
      end
    end

    if (P_LATENCY == 2) begin : g_lat2
      logic [P_DWIDTH-1:0] r_out_data;
      logic                r_out_vld;

      always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
          r_out_data <= '0;
          r_out_vld  <= 1'b0;
        end else begin
          r_out_vld <= r_s1_vld;
          if (r_s1_vld) begin
            r_out_data <= r_s1_data;
          end
        end
      end

      assign w_dout[p] = r_out_data;
      assign w_vld[p]  = r_out_vld;
    end else begin : g_lat1
      assign w_dout[p] = r_s1_data;
      assign w_vld[p]  = r_s1_vld;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bram_dual_port.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_dual_port
//  Description : Scoreboard bench for bram_dual_port over five latency/write
//                mode builds driven by one shared stimulus stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_dual_port;

  localparam int ND = 5;
  localparam int LAT [ND] = '{1, 1, 1, 2, 2};
  localparam int WM  [ND] = '{0, 1, 2, 0, 1};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0, enb = 1'b0;
  logic [3:0]  wea = '0, web = '0;
  logic [3:0]  addra = '0, addrb = '0;
  logic [31:0] dina = '0, dinb = '0;
  logic [31:0] douta [ND];
  logic [31:0] doutb [ND];
  logic        valida [ND];
  logic        validb [ND];

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [31:0] mdl [16];
  logic [31:0] qd [2*ND][$];
  int          qt [2*ND][$];
  logic [31:0] last [2*ND];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  for (genvar d = 0; d < ND; d++) begin : g_dut
    bram_dual_port #(
      .P_DWIDTH (32),
      .P_SIZE   (64),
      .P_LATENCY(LAT[d]),
      .P_WMODE  (WM[d])
    ) u_dut (
      .CLK   (clk),
      .RESETn(rst_n),
      .ADDRA (addra),
      .ENA   (ena),
      .WEA   (wea),
      .DINA  (dina),
      .DOUTA (douta[d]),
      .VALIDA(valida[d]),
      .ADDRB (addrb),
      .ENB   (enb),
      .WEB   (web),
      .DINB  (dinb),
      .DOUTB (doutb[d]),
      .VALIDB(validb[d])
    );
  end

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] dn,
                                        input logic [3:0] we);
    for (int i = 0; i < 4; i++) if (we[i]) o[8*i +: 8] = dn[8*i +: 8];
    return o;
  endfunction

  // Spec-level rule for what a port returns on an access, pushed with the
  // negedge at which the data is due.
  task automatic expect_port(input int k, input int mode, input int lat, input logic [3:0] we,
                             input logic [31:0] old_w, input logic [31:0] dn);
    if (mode == 2 && we != 4'h0) return;
    qd[k].push_back((mode == 1) ? merge(old_w, dn, we) : old_w);
    qt[k].push_back(cyc + lat);
  endtask

  task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa,
                       input logic [31:0] da, input logic eb, input logic [3:0] wb,
                       input logic [3:0] ab, input logic [31:0] db);
    @(negedge clk);
    ena = ea; wea = wa; addra = aa; dina = da;
    enb = eb; web = wb; addrb = ab; dinb = db;
    for (int d = 0; d < ND; d++) begin
      if (ea) expect_port(2*d,   WM[d], LAT[d], wa, mdl[aa], da);
      if (eb) expect_port(2*d+1, WM[d], LAT[d], wb, mdl[ab], db);
    end
    if (eb) mdl[ab] = merge(mdl[ab], db, wb);
    if (ea) mdl[aa] = merge(mdl[aa], da, wa);
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  // Monitor: every port of every build is checked once per cycle.
  initial begin
    int k;
    logic v;
    logic [31:0] o;
    for (int i = 0; i < 2*ND; i++) last[i] = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < 2; p++) begin
          k = 2*d + p;
          v = (p == 0) ? valida[d] : validb[d];
          o = (p == 0) ? douta[d] : doutb[d];
          total++;
          if (v === 1'b1) begin
            if (qd[k].size() == 0) begin
              bad++;
              $display("FAIL unexpected_valid d%0d p%0d cyc=%0d got=%h", d, p, cyc, o);
            end else begin
              if (o !== qd[k][0] || qt[k][0] != cyc) begin
                bad++;
                $display("FAIL read_data d%0d p%0d cyc=%0d got=%h exp=%h due_cyc=%0d",
                         d, p, cyc, o, qd[k][0], qt[k][0]);
              end
              last[k] = qd[k].pop_front();
              void'(qt[k].pop_front());
            end
          end else begin
            if (v !== 1'b0 || o !== last[k]) begin
              bad++;
              $display("FAIL hold d%0d p%0d cyc=%0d got=%h valid=%b exp=%h valid=0",
                       d, p, cyc, o, v, last[k]);
            end
            if (qd[k].size() != 0 && qt[k][0] < cyc) begin
              bad++;
              $display("FAIL missing_valid d%0d p%0d cyc=%0d exp=%h due_cyc=%0d",
                       d, p, cyc, qd[k][0], qt[k][0]);
              void'(qd[k].pop_front());
              void'(qt[k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic ea, eb;
    logic [3:0] wa, wb, aa, ab;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Fill: words 0..3 with the incrementing pattern, the rest random.
    for (int w = 0; w < 16; w++) begin
      if (w < 4) drive(1, 4'hF, 4'(w), 32'h44332211 + 32'h11111111 * w, 0, 4'h0, 4'h0, 32'h0);
      else       drive(1, 4'hF, 4'(w), $urandom, 0, 4'h0, 4'h0, 32'h0);
    end
    for (int w = 0; w < 4; w++) drive(1, 4'h0, 4'(w), 32'h0, 0, 4'h0, 4'h0, 32'h0);

    // Byte-enable merge, read back on B.
    drive(1, 4'hF, 4'd5, 32'h44332211, 0, 4'h0, 4'h0, 32'h0);
    drive(1, 4'b0101, 4'd5, 32'hAABBCCDD, 0, 4'h0, 4'h0, 32'h0);
    drive(0, 4'h0, 4'h0, 32'h0, 1, 4'h0, 4'd5, 32'h0);

    // Write-mode observation: 0xDEADBEEF over 0x12345678.
    drive(1, 4'hF, 4'd9, 32'h12345678, 0, 4'h0, 4'h0, 32'h0);
    drive(1, 4'hF, 4'd9, 32'hDEADBEEF, 0, 4'h0, 4'h0, 32'h0);
    idle();

    // Cross-port collisions at word 7.
    drive(1, 4'hF, 4'd7, 32'h11111111, 1, 4'b1100, 4'd7, 32'h22222222);
    drive(1, 4'hF, 4'd7, 32'hCAFEF00D, 1, 4'h0, 4'd7, 32'h0);
    drive(1, 4'h0, 4'd7, 32'h0, 1, 4'h0, 4'd7, 32'h0);

    // Back-to-back reads of words 0..3 on both ports.
    for (int w = 0; w < 4; w++) drive(1, 4'h0, 4'(w), 32'h0, 1, 4'h0, 4'(3 - w), 32'h0);
    repeat (3) idle();

    // Reset between the read edge and the latency-2 output edge.
    drive(1, 4'h0, 4'd2, 32'h0, 1, 4'h0, 4'd1, 32'h0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) begin
      total++;
      if (douta[d] !== 32'h0 || valida[d] !== 1'b0 || doutb[d] !== 32'h0 || validb[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_clear d%0d got douta=%h valida=%b doutb=%h validb=%b exp all 0",
                 d, douta[d], valida[d], doutb[d], validb[d]);
      end
    end
    for (int i = 0; i < 2*ND; i++) begin
      qd[i].delete();
      qt[i].delete();
      last[i] = 32'h0;
    end
    #1 rst_n = 1'b1;
    repeat (2) idle();
    for (int w = 0; w < 4; w++) drive(1, 4'h0, 4'(w), 32'h0, 1, 4'h0, 4'(w + 4), 32'h0);

    // Randomised traffic over a small address space to force collisions.
    repeat (400) begin
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      wb = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      aa = 4'($urandom);
      ab = ($urandom_range(0, 2) == 0) ? aa : 4'($urandom);
      drive(ea, wa, aa, $urandom, eb, wb, ab, $urandom);
    end
    for (int w = 0; w < 16; w++) drive(1, 4'h0, 4'(w), 32'h0, 1, 4'h0, 4'(15 - w), 32'h0);
    repeat (4) idle();

    for (int i = 0; i < 2*ND; i++) begin
      total++;
      if (qd[i].size() != 0) begin
        bad++;
        $display("FAIL drain queue=%0d got pending=%0d exp pending=0", i, qd[i].size());
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
